sim_io_monitor: RTL and testbench
=================================

// Module: sim_io_monitor
// PURPOSE
//  Simulation-side consumer of the CPU's memory-mapped I/O writes, sitting between riscv_top's RAM/IO bus and the testbench.
//  Captures console bytes and the end-of-program write; buffers bytes in a FIFO and drains them over a valid/ready byte stream.
//  Raises done when all buffered bytes are out, and raises timeout if the program never finishes.
// PARAMETERS
//  DEPTH_LOG2  4          FIFO depth = 2**DEPTH_LOG2 bytes
//  CHAR_ADDR   18'h30000  write here = console byte
//  END_ADDR    18'h30004  write here = program end, data byte = exit code
//  TIMEOUT     32'd2000000  cycles without any I/O write before timeout (0 disables)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  io_wr      in   1   bus write strobe, one byte per cycle
//  io_addr    in   18  bus byte address
//  io_wdata   in   8   bus write data
//  tx_valid   out  1   tx_byte valid
//  tx_byte    out  8   head-of-FIFO byte
//  tx_ready   in   1   consumer accepts byte when tx_valid&tx_ready
//  exit_code  out  8   latched END_ADDR data
//  done       out  1   sticky: program ended and FIFO fully drained
//  timeout    out  1   sticky: TIMEOUT idle cycles elapsed in RUN
//  overflow   out  1   sticky: a console byte was dropped because FIFO full
//  fifo_cnt   out  DEPTH_LOG2+1  current occupancy
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, fifo_cnt=0, tx_valid=0, tx_byte=0, exit_code=0,
//   done=0, timeout=0, overflow=0, idle counter=0, state=RUN. Reset mid-drain discards all buffered bytes.
//  Accepted write = io_wr=1 and io_addr==CHAR_ADDR or END_ADDR; other addresses ignored entirely (no counter reset).
//  FIFO: push on CHAR write in RUN when not full; pop on tx_valid&tx_ready. Push and pop in the same cycle
//   keeps fifo_cnt; allowed when full (pop frees the slot) and when empty (byte not yet visible, no bypass).
//  CHAR write with FIFO full and no same-cycle pop: byte dropped, overflow<=1.
//  tx_valid = (fifo_cnt!=0) registered-equivalent; tx_byte = head entry, stable while tx_valid&!tx_ready.
//  Pointers wrap modulo 2**DEPTH_LOG2; fifo_cnt ranges 0..2**DEPTH_LOG2.
//  Latency: byte written cycle N appears on tx_byte/tx_valid at cycle N+1.
//  FSM states:
//   RUN    : accepts CHAR and END writes; END write -> exit_code<=io_wdata, go DRAIN.
//            idle counter clears on any accepted write, else increments; reaching TIMEOUT (TIMEOUT!=0)
//            -> timeout<=1, go HALT.
//   DRAIN  : further writes (CHAR or END) ignored; pops continue; fifo_cnt==0 -> done<=1, go HALT.
//   HALT   : terminal; outputs hold; pops may still empty FIFO after timeout; only reset leaves.
//  CHAR and END are distinct addresses so cannot coincide; END with empty FIFO: DRAIN then HALT next cycle
//   (done asserted 2 cycles after the END write).
//  Idle counter is 32 bits, saturates, no wrap.
// TESTING
//  1 Reset: hold rst_n=0 with io_wr=1 -> all outputs 0, fifo_cnt=0; release -> no spurious push.
//  2 Write 'H','i' to 0x30000, tx_ready=1 -> tx_byte 8'h48 then 8'h69 on consecutive cycles, fifo_cnt back to 0.
//  3 tx_ready=0, write 17 bytes (DEPTH_LOG2=4) -> fifo_cnt=16, overflow=1, 17th byte absent on drain.
//  4 Full FIFO, push+pop same cycle -> fifo_cnt stays 16, overflow stays 0, order preserved.
//  5 Write 3 bytes, then END with 8'd7, tx_ready=0 for 10 cycles then 1 -> done=0 until 3rd pop, then
//    done=1, exit_code=7; later CHAR writes ignored.
//  6 TIMEOUT=100, no writes after reset -> timeout=1 at cycle 100, done=0; write to 0x30008 does not reset counter.

Source files
------------

// File: rtl/sim_io_monitor.sv
// rtl/sim_io_monitor.sv - simulation I/O monitor: console byte FIFO, program-end capture, idle timeout
//
// Purpose:
//   Watches the CPU's memory-mapped write bus. Writes to CHAR_ADDR queue a
//   console byte in a small FIFO that drains over a valid/ready byte stream.
//   A write to END_ADDR latches the exit code and, once every buffered byte
//   has been handed out, raises done. If no accepted write arrives for
//   TIMEOUT cycles while running, timeout is raised instead.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   io_wr      bus write strobe
//   io_addr    bus byte address (18 bits)
//   io_wdata   bus write data byte
//   tx_valid   head-of-FIFO byte is valid
//   tx_byte    head-of-FIFO byte (0 when empty)
//   tx_ready   consumer accepts tx_byte when tx_valid & tx_ready
//   exit_code  data byte of the END_ADDR write
//   done       sticky: program ended and FIFO drained
//   timeout    sticky: TIMEOUT idle cycles elapsed while running
//   overflow   sticky: a console byte was dropped on a full FIFO
//   fifo_cnt   current FIFO occupancy, 0..2**DEPTH_LOG2

module sim_io_monitor #(
   parameter int          DEPTH_LOG2 = 4,
   parameter logic [17:0] CHAR_ADDR  = 18'h30000,
   parameter logic [17:0] END_ADDR   = 18'h30004,
   parameter logic [31:0] TIMEOUT    = 32'd2000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  io_wr,
   input  logic [17:0]           io_addr,
   input  logic [7:0]            io_wdata,
   output logic                  tx_valid,
   output logic [7:0]            tx_byte,
   input  logic                  tx_ready,
   output logic [7:0]            exit_code,
   output logic                  done,
   output logic                  timeout,
   output logic                  overflow,
   output logic [DEPTH_LOG2:0]   fifo_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [7:0]              mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]     cnt;
   logic [31:0]             idle_cnt;
   logic [31:0]             idle_inc;

   logic is_char, is_end, pop, full;
   logic push, drop, set_done, set_timeout, latch_exit, idle_clr;

   assign is_char  = io_wr && (io_addr == CHAR_ADDR);
   assign is_end   = io_wr && (io_addr == END_ADDR);
   assign full     = (cnt == FULL_CNT);
   assign tx_valid = (cnt != '0);
   assign pop      = tx_valid && tx_ready;
   // Empty FIFO shows 0 rather than a stale or never-written entry.
   assign tx_byte  = tx_valid ? mem[rd_ptr] : 8'h00;
   assign fifo_cnt = cnt;

   // Saturating increment: the idle counter must never wrap back to 0.
   assign idle_inc = (idle_cnt == 32'hFFFF_FFFF) ? idle_cnt : idle_cnt + 32'd1;

   always_comb begin
      state_d     = state_q;
      push        = 1'b0;
      drop        = 1'b0;
      set_done    = 1'b0;
      set_timeout = 1'b0;
      latch_exit  = 1'b0;
      idle_clr    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (is_char) begin
               // A same-cycle pop frees a slot, so a full FIFO can still accept.
               if (!full || pop) push = 1'b1;
               else              drop = 1'b1;
            end
            if (is_end) begin
               latch_exit = 1'b1;
               state_d    = ST_DRAIN;
            end
            if (is_char || is_end) begin
               idle_clr = 1'b1;
            end else if ((TIMEOUT != 32'd0) && (idle_inc >= TIMEOUT)) begin
               set_timeout = 1'b1;
               state_d     = ST_HALT;
            end
         end
         ST_DRAIN: begin
            if (cnt == '0) begin
               set_done = 1'b1;
               state_d  = ST_HALT;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         idle_cnt  <= 32'd0;
         exit_code <= 8'h00;
         done      <= 1'b0;
         timeout   <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (state_q == ST_RUN) begin
            idle_cnt <= idle_clr ? 32'd0 : idle_inc;
         end
         if (latch_exit)  exit_code <= io_wdata;
         if (set_done)    done      <= 1'b1;
         if (set_timeout) timeout   <= 1'b1;
         if (drop)        overflow  <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible once counted in cnt.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= io_wdata;
   end

endmodule

// File: tb/tb_sim_io_monitor.sv
// tb/tb_sim_io_monitor.sv - self-checking bench for sim_io_monitor with queue reference model

module tb_sim_io_monitor;

   localparam logic [17:0] CHAR  = 18'h30000;
   localparam logic [17:0] ENDA  = 18'h30004;
   localparam logic [17:0] OTHER = 18'h30008;
   localparam int          TO    = 100;
   localparam int          DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        io_wr = 1'b0;
   logic [17:0] io_addr = '0;
   logic [7:0]  io_wdata = '0;
   logic        tx_ready = 1'b0;
   logic        tx_valid;
   logic [7:0]  tx_byte;
   logic [7:0]  exit_code;
   logic        done;
   logic        timeout;
   logic        overflow;
   logic [4:0]  fifo_cnt;

   int total = 0;
   int bad   = 0;

   sim_io_monitor #(
      .DEPTH_LOG2(4),
      .CHAR_ADDR (CHAR),
      .END_ADDR  (ENDA),
      .TIMEOUT   (32'(TO))
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .io_wr     (io_wr),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .tx_valid  (tx_valid),
      .tx_byte   (tx_byte),
      .tx_ready  (tx_ready),
      .exit_code (exit_code),
      .done      (done),
      .timeout   (timeout),
      .overflow  (overflow),
      .fifo_cnt  (fifo_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: a byte queue plus the program's phase (0 run, 1 drain, 2 halted)
   logic [7:0] mq[$];
   int         m_mode;
   logic [7:0] m_exit;
   bit         m_done, m_to, m_ovf;
   longint     m_idle;

   task automatic m_reset();
      mq.delete();
      m_mode = 0;
      m_exit = 8'h00;
      m_done = 1'b0;
      m_to   = 1'b0;
      m_ovf  = 1'b0;
      m_idle = 0;
   endtask

   task automatic m_step(input bit wr, input logic [17:0] a, input logic [7:0] d, input bit rdy);
      int n0  = mq.size();
      bit pop = (n0 > 0) && rdy;
      bit acc = wr && ((a == CHAR) || (a == ENDA));
      if (pop) void'(mq.pop_front());
      case (m_mode)
         0: begin
            if (wr && a == CHAR) begin
               if (n0 < DEPTH || pop) mq.push_back(d);
               else                   m_ovf = 1'b1;
            end
            if (wr && a == ENDA) begin
               m_exit = d;
               m_mode = 1;
            end
            if (acc) m_idle = 0;
            else begin
               if (m_idle < 64'hFFFF_FFFF) m_idle++;
               if (m_idle >= TO) begin
                  m_to   = 1'b1;
                  m_mode = 2;
               end
            end
         end
         1: begin
            if (n0 == 0) begin
               m_done = 1'b1;
               m_mode = 2;
            end
         end
         default: ;
      endcase
   endtask

   task automatic cyc(input bit wr, input logic [17:0] a, input logic [7:0] d, input bit rdy);
      io_wr    = wr;
      io_addr  = a;
      io_wdata = d;
      tx_ready = rdy;
      @(posedge clk);
      m_step(wr, a, d, rdy);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      io_wr = 1'b0;
      tx_ready = 1'b0;
      m_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      io_wr    = 1'b1;
      io_addr  = CHAR;
      io_wdata = 8'h55;
      tx_ready = 1'b1;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({tx_valid, tx_byte, exit_code, done, timeout, overflow, fifo_cnt} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {tx_valid, tx_byte, exit_code, done, timeout, overflow, fifo_cnt});
      end
      io_wr = 1'b0;
      rst_n = 1'b1;
      cyc(0, CHAR, 8'h00, 1'b0);
      total++;
      if (fifo_cnt !== 5'd0 || tx_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release got cnt=%0d valid=%b exp cnt=0 valid=0", fifo_cnt, tx_valid);
      end
   endtask

   task automatic test_hi();
      do_reset();
      cyc(1, CHAR, 8'h48, 1'b1);
      total++;
      if (tx_valid !== 1'b1 || tx_byte !== 8'h48) begin
         bad++;
         $display("FAIL hi_first got v=%b b=%h exp v=1 b=48", tx_valid, tx_byte);
      end
      cyc(1, CHAR, 8'h69, 1'b1);
      total++;
      if (tx_valid !== 1'b1 || tx_byte !== 8'h69 || fifo_cnt !== 5'd1) begin
         bad++;
         $display("FAIL hi_second got v=%b b=%h cnt=%0d exp v=1 b=69 cnt=1", tx_valid, tx_byte, fifo_cnt);
      end
      cyc(0, CHAR, 8'h00, 1'b1);
      total++;
      if (fifo_cnt !== 5'd0 || tx_valid !== 1'b0) begin
         bad++;
         $display("FAIL hi_empty got cnt=%0d v=%b exp cnt=0 v=0", fifo_cnt, tx_valid);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] sent[$];
      do_reset();
      for (int i = 0; i < 17; i++) begin
         logic [7:0] b = 8'($urandom);
         sent.push_back(b);
         cyc(1, CHAR, b, 1'b0);
      end
      total++;
      if (fifo_cnt !== 5'd16 || overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_full got cnt=%0d ovf=%b exp cnt=16 ovf=1", fifo_cnt, overflow);
      end
      for (int k = 0; k < 16; k++) begin
         total++;
         if (tx_valid !== 1'b1 || tx_byte !== sent[k]) begin
            bad++;
            $display("FAIL ovf_drain k=%0d got v=%b b=%h exp v=1 b=%h", k, tx_valid, tx_byte, sent[k]);
         end
         cyc(0, CHAR, 8'h00, 1'b1);
      end
      total++;
      if (tx_valid !== 1'b0 || fifo_cnt !== 5'd0) begin
         bad++;
         $display("FAIL ovf_17th_absent got v=%b cnt=%0d exp v=0 cnt=0", tx_valid, fifo_cnt);
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1, CHAR, 8'(8'h10 + i), 1'b0);
      cyc(1, CHAR, 8'hAA, 1'b1);
      total++;
      if (fifo_cnt !== 5'd16 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL fullpp_cnt got cnt=%0d ovf=%b exp cnt=16 ovf=0", fifo_cnt, overflow);
      end
      for (int k = 0; k < 16; k++) begin
         logic [7:0] e = (k == 15) ? 8'hAA : 8'(8'h11 + k);
         total++;
         if (tx_valid !== 1'b1 || tx_byte !== e) begin
            bad++;
            $display("FAIL fullpp_order k=%0d got b=%h exp b=%h", k, tx_byte, e);
         end
         cyc(0, CHAR, 8'h00, 1'b1);
      end
   endtask

   task automatic test_end_drain();
      int n;
      do_reset();
      cyc(1, CHAR, 8'h31, 1'b0);
      cyc(1, CHAR, 8'h32, 1'b0);
      cyc(1, CHAR, 8'h33, 1'b0);
      cyc(1, ENDA, 8'd7, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cyc(1, CHAR, 8'hEE, 1'b0);
         total++;
         if (done !== 1'b0 || fifo_cnt !== 5'd3) begin
            bad++;
            $display("FAIL end_hold i=%0d got done=%b cnt=%0d exp done=0 cnt=3", i, done, fifo_cnt);
         end
      end
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         cyc(1, CHAR, 8'hEE, 1'b1);
         n++;
         total++;
         if (done !== m_done || fifo_cnt !== 5'(mq.size())) begin
            bad++;
            $display("FAIL end_drain n=%0d got done=%b cnt=%0d exp done=%b cnt=%0d",
                     n, done, fifo_cnt, m_done, mq.size());
         end
      end
      total++;
      if (done !== 1'b1 || exit_code !== 8'd7 || n != 4) begin
         bad++;
         $display("FAIL end_final got done=%b exit=%0d cycles=%0d exp done=1 exit=7 cycles=4",
                  done, exit_code, n);
      end
      cyc(1, CHAR, 8'h44, 1'b0);
      cyc(1, ENDA, 8'd9, 1'b0);
      total++;
      if (fifo_cnt !== 5'd0 || exit_code !== 8'd7 || done !== 1'b1) begin
         bad++;
         $display("FAIL end_ignore got cnt=%0d exit=%0d done=%b exp cnt=0 exit=7 done=1",
                  fifo_cnt, exit_code, done);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 1; i <= TO + 5; i++) begin
         bit other = (i % 7) == 0;
         bit exp_to = (i >= TO);
         cyc(other, OTHER, 8'h5A, 1'b0);
         total++;
         if (timeout !== exp_to || done !== 1'b0) begin
            bad++;
            $display("FAIL timeout_cycle i=%0d got to=%b done=%b exp to=%b done=0", i, timeout, done, exp_to);
         end
      end
      cyc(1, CHAR, 8'h01, 1'b0);
      total++;
      if (fifo_cnt !== 5'd0 || timeout !== 1'b1) begin
         bad++;
         $display("FAIL timeout_halt got cnt=%0d to=%b exp cnt=0 to=1", fifo_cnt, timeout);
      end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, CHAR, 8'(i + 1), 1'b0);
      cyc(0, CHAR, 8'h00, 1'b1);
      rst_n = 1'b0;
      m_reset();
      #2;
      total++;
      if (fifo_cnt !== 5'd0 || tx_valid !== 1'b0 || tx_byte !== 8'h00) begin
         bad++;
         $display("FAIL midreset got cnt=%0d v=%b b=%h exp cnt=0 v=0 b=00", fifo_cnt, tx_valid, tx_byte);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 500; c++) begin
         int r = int'($urandom_range(0, 99));
         bit wr = r < 65;
         logic [17:0] a = (r < 55) ? CHAR : (r < 63) ? OTHER : (r < 64) ? ENDA : 18'h00123;
         cyc(wr, a, 8'($urandom), 1'($urandom_range(0, 2) == 0));
         total++;
         if (fifo_cnt !== 5'(mq.size()) || tx_valid !== (mq.size() != 0)) begin
            bad++;
            $display("FAIL rand_cnt c=%0d got cnt=%0d v=%b exp cnt=%0d", c, fifo_cnt, tx_valid, mq.size());
         end else if (mq.size() != 0 && tx_byte !== mq[0]) begin
            bad++;
            $display("FAIL rand_byte c=%0d got %h exp %h", c, tx_byte, mq[0]);
         end
         total++;
         if ({done, timeout, overflow, exit_code} !== {m_done, m_to, m_ovf, m_exit}) begin
            bad++;
            $display("FAIL rand_flags c=%0d got d/t/o/x=%b%b%b/%h exp %b%b%b/%h",
                     c, done, timeout, overflow, exit_code, m_done, m_to, m_ovf, m_exit);
         end
      end
   endtask

   initial begin
      test_reset();
      test_hi();
      test_overflow();
      test_full_push_pop();
      test_end_drain();
      test_timeout();
      test_reset_mid_drain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
